// File: rtl/serial_comparator.sv
// Multi-cycle MSB-first magnitude comparator: walks WIDTH-bit operands DIGIT bits per clock
// and stops at the first differing chunk, reporting bigger/equal/smallest with a done pulse.
module serial_comparator #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic             bigger,
  output logic             equal,
  output logic             smallest
);

  localparam int unsigned N    = WIDTH / DIGIT;
  localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IdxW-1:0] IdxLast = IdxW'(N - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [IdxW-1:0]  idx_q, idx_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic             bigger_q, bigger_d;
  logic             equal_q, equal_d;
  logic             smallest_q, smallest_d;
  logic [DIGIT-1:0] a_chunk, b_chunk;
  logic [WIDTH-1:0] sign_flip;

  // Flipping the MSB of both operands maps two's-complement order onto unsigned order.
  assign sign_flip = {is_signed, {(WIDTH-1){1'b0}}};

  always_comb begin
    a_chunk = '0;
    b_chunk = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (idx_q == IdxW'(i)) begin
        a_chunk = a_q[i*DIGIT +: DIGIT];
        b_chunk = b_q[i*DIGIT +: DIGIT];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    a_d        = a_q;
    b_d        = b_q;
    bigger_d   = bigger_q;
    equal_d    = equal_q;
    smallest_d = smallest_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = A ^ sign_flip;
          b_d     = B ^ sign_flip;
          idx_d   = IdxLast;
          state_d = RUN;
        end
      end
      RUN: begin
        if (a_chunk > b_chunk) begin
          bigger_d   = 1'b1;
          equal_d    = 1'b0;
          smallest_d = 1'b0;
          state_d    = DONE;
        end else if (a_chunk < b_chunk) begin
          bigger_d   = 1'b0;
          equal_d    = 1'b0;
          smallest_d = 1'b1;
          state_d    = DONE;
        end else if (idx_q == '0) begin
          bigger_d   = 1'b0;
          equal_d    = 1'b1;
          smallest_d = 1'b0;
          state_d    = DONE;
        end else begin
          idx_d = idx_q - 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      a_q        <= '0;
      b_q        <= '0;
      bigger_q   <= 1'b0;
      equal_q    <= 1'b0;
      smallest_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      a_q        <= a_d;
      b_q        <= b_d;
      bigger_q   <= bigger_d;
      equal_q    <= equal_d;
      smallest_q <= smallest_d;
    end
  end

  assign busy     = (state_q != IDLE);
  assign done     = (state_q == DONE);
  assign bigger   = bigger_q;
  assign equal    = equal_q;
  assign smallest = smallest_q;

endmodule

// File: doc/serial_comparator.md
# serial_comparator

Parametrised, multi-cycle magnitude comparator for the processor datapath, replacing the fixed 8-bit single-cycle unit. It compares two WIDTH-bit operands MSB-first, DIGIT bits per clock, in unsigned or two's-complement mode. It stops at the first differing chunk and reports bigger/equal/smallest through a start/busy/done handshake. The ALU flag logic and branch-condition unit consume it.

## Interface
- WIDTH, 16, operand width in bits; must be ≥ 2.
- DIGIT, 4, bits compared per cycle; WIDTH must be an integer multiple of DIGIT; N = WIDTH/DIGIT chunks.
- clk  input  1  single clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request; sampled only while busy = 0.
- is_signed  input  1  1 = two's-complement compare, 0 = unsigned; sampled with start.
- A  input  WIDTH  first operand; sampled with start.
- B  input  WIDTH  second operand; sampled with start.
- busy  output  1  high from the cycle after start is accepted through the done cycle.
- done  output  1  one-cycle pulse; result flags are valid in this cycle.
- bigger  output  1  A > B under the sampled mode.
- equal  output  1  A == B.
- smallest  output  1  A < B under the sampled mode.

## Operation
- Reset (rst_n = 0, any time, asynchronous): state is IDLE. busy, done, bigger, equal and smallest are all 0. The chunk counter is cleared and the operand registers are don't-care. Reset in the middle of a compare abandons it with no done pulse.
- FSM states are IDLE, RUN and DONE.
- IDLE: busy = 0. On a clock edge with start = 1:
  - Register A and B. When is_signed = 1, invert bit WIDTH-1 of both registered copies, which maps signed order onto unsigned order.
  - Load the chunk index with N-1 and go to RUN.
- RUN: each cycle compares the operand chunk [idx*DIGIT +: DIGIT] as unsigned values.
  - Chunk of A > chunk of B: register bigger = 1, equal = 0, smallest = 0, go to DONE.
  - Chunk of A < chunk of B: register smallest = 1, the other two flags 0, go to DONE.
  - Chunks equal and idx = 0: register equal = 1, the other two flags 0, go to DONE.
  - Chunks equal and idx > 0: decrement idx and stay in RUN.
- DONE: done = 1 for exactly one cycle, then return to IDLE.
- Flags are updated only on the edge that enters DONE. They hold their value through IDLE until the next decision or reset, and are never simultaneously 1.
- start while busy = 1 (RUN or DONE) is ignored and not queued. Changes to A, B or is_signed after acceptance have no effect.

## Timing
- Start accepted at edge 0. The chunk decided at edge k enters DONE, so done is high in cycle k+1.
- Latency from the accepting edge to the done cycle:
  - Minimum 2 cycles: the MSB chunk differs.
  - Maximum N+1 cycles: the LSB chunk differs, or the operands are equal.
- Throughput: the earliest next accepted start is the edge that ends the done cycle, where state is IDLE and busy = 0. Start held high continuously therefore gives one compare every latency+1 cycles.
- busy rises the cycle after acceptance and falls with the edge that ends done.
- With DIGIT = WIDTH (N = 1), latency is always 2.

## Test plan
- WIDTH=16, DIGIT=4, unsigned, A=0x8000, B=0x7FFF → bigger=1, done pulses 2 cycles after acceptance, busy high for exactly 2 cycles.
- Same operands, is_signed=1 → smallest=1, equal=0, bigger=0, latency 2.
- Unsigned, A=B=0x1234 → equal=1 at N+1=5 cycles. Then A=0x1235, B=0x1234 → bigger=1 at 5 cycles. Then A=0x1234, B=0x1334 → smallest=1 at 3 cycles.
- Start held high for 20 cycles with A=0xFFFF, B=0x0000 → done every 3 cycles, flags stable between pulses, no acceptance while busy. Changing A during RUN does not alter the result.
- Reset: assert rst_n=0 mid-RUN (A=0x0001, B=0x0002) → all outputs 0 immediately, without waiting for a clock edge, and no done pulse. After release, a new compare behaves normally.
- WIDTH=8, DIGIT=1, signed, A=0x80, B=0x7F → smallest=1 at 2 cycles; A=0xFE, B=0xFF → smallest=1 at 9 cycles; A=B=0x00 → equal at 9 cycles.
